// File: rtl/dct_pkg.sv
// Shared widths, types, FSM states and the 8x8 DCT coefficient table for the row multiplier.
package dct_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 6;
  localparam int unsigned PROD_W = 14;
  localparam int unsigned ROW_N  = 8;
  localparam int unsigned IDX_W  = 3;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PIX_W-1:0]  pix_s_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic {IDLE, RUN} state_e;

  // C[k][i] = round(32 * c_k * cos((2i+1) k pi / 16)); row k, column i
  localparam coef_t COEF_TAB [ROW_N][ROW_N] = '{
    '{ 6'sd11,  6'sd11,  6'sd11,  6'sd11,  6'sd11,  6'sd11,  6'sd11,  6'sd11},
    '{ 6'sd16,  6'sd13,  6'sd9,   6'sd3,  -6'sd3,  -6'sd9,  -6'sd13, -6'sd16},
    '{ 6'sd15,  6'sd6,  -6'sd6,  -6'sd15, -6'sd15, -6'sd6,   6'sd6,   6'sd15},
    '{ 6'sd13, -6'sd3,  -6'sd16, -6'sd9,   6'sd9,   6'sd16,  6'sd3,  -6'sd13},
    '{ 6'sd11, -6'sd11, -6'sd11,  6'sd11,  6'sd11, -6'sd11, -6'sd11,  6'sd11},
    '{ 6'sd9,  -6'sd16,  6'sd3,   6'sd13, -6'sd13, -6'sd3,   6'sd16, -6'sd9},
    '{ 6'sd6,  -6'sd15,  6'sd15, -6'sd6,  -6'sd6,   6'sd15, -6'sd15,  6'sd6},
    '{ 6'sd3,  -6'sd9,   6'sd13, -6'sd16,  6'sd16, -6'sd13,  6'sd9,  -6'sd3}
  };

endpackage

// File: rtl/dct_row_mult_if.sv
// Pixel input and product-set output bundle of the DCT row multiplier.
interface dct_row_mult_if;

  logic                                 sof;
  logic                                 pix_valid;
  logic [dct_pkg::PIX_W-1:0]            pix_in;
  logic                                 pix_ready;
  dct_pkg::prod_t                       n0, n1, n2, n3, n4, n5, n6, n7;
  logic                                 out_valid;
  logic [dct_pkg::IDX_W-1:0]            k_idx;
  logic [dct_pkg::IDX_W-1:0]            row_idx;

  modport slave (
    input  sof, pix_valid, pix_in,
    output pix_ready, n0, n1, n2, n3, n4, n5, n6, n7, out_valid, k_idx, row_idx
  );

  modport master (
    output sof, pix_valid, pix_in,
    input  pix_ready, n0, n1, n2, n3, n4, n5, n6, n7, out_valid, k_idx, row_idx
  );

endinterface

// File: rtl/dct_coef_rom.sv
// Combinational lookup of the eight coefficients C[k][0..7] for one output index k.
module dct_coef_rom
  import dct_pkg::*;
(
  input  logic [IDX_W-1:0]        k_i,
  output coef_t [ROW_N-1:0]       coef_o
);

  always_comb begin
    coef_o = '0;
    for (int i = 0; i < ROW_N; i++) begin
      coef_o[i] = COEF_TAB[k_i][i];
    end
  end

endmodule

// File: rtl/dct_row_mult.sv
// Row DCT front stage: gathers 8 level-shifted pixels, then emits one registered
// product set x_i*C[k][i] per cycle for k = 0..7.
module dct_row_mult
  import dct_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dct_row_mult_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic               row_sof_q, row_sof_d;
  pix_s_t             lbuf_q [ROW_N-1];
  pix_s_t             lbuf_d [ROW_N-1];
  pix_s_t             cbuf_q [ROW_N];
  pix_s_t             cbuf_d [ROW_N];
  prod_t              prod_q [ROW_N];
  prod_t              prod_d [ROW_N];
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   k_idx_q, k_idx_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;

  coef_t [ROW_N-1:0]  coef;
  pix_s_t             x;
  logic [IDX_W-1:0]   eff_cnt;
  logic               transfer;

  dct_coef_rom u_rom (
    .k_i    (k_q),
    .coef_o (coef)
  );

  // Inverting the MSB is the same as subtracting 128 into two's complement
  assign x = pix_s_t'({~bus.pix_in[PIX_W-1], bus.pix_in[PIX_W-2:0]});

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pix_cnt_d   = pix_cnt_q;
    row_cnt_d   = row_cnt_q;
    row_sof_d   = row_sof_q;
    lbuf_d      = lbuf_q;
    cbuf_d      = cbuf_q;
    prod_d      = prod_q;
    out_valid_d = 1'b0;
    k_idx_d     = k_idx_q;
    row_idx_d   = row_idx_q;

    // sof realigns before the write, so a sof pixel is always x_0 and never completes a row
    eff_cnt  = bus.sof ? '0 : pix_cnt_q;
    transfer = bus.pix_valid && (eff_cnt == IDX_W'(ROW_N - 1));

    pix_cnt_d = eff_cnt;
    if (bus.pix_valid) begin
      pix_cnt_d = eff_cnt + IDX_W'(1);
      if (eff_cnt == '0) begin
        row_sof_d = bus.sof;
      end
      if (!transfer) begin
        lbuf_d[eff_cnt] = x;
      end
    end

    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
      end
      RUN: begin
        out_valid_d = 1'b1;
        k_idx_d     = k_q;
        row_idx_d   = row_cnt_q;
        for (int i = 0; i < ROW_N; i++) begin
          prod_d[i] = PROD_W'(cbuf_q[i]) * PROD_W'(coef[i]);
        end
        k_d = k_q + IDX_W'(1);
        if (k_q == IDX_W'(ROW_N - 1)) begin
          row_cnt_d = row_cnt_q + IDX_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed row starts a fresh pass; a sof-aligned row restarts row numbering
    if (transfer) begin
      state_d = RUN;
      k_d     = '0;
      for (int i = 0; i < ROW_N - 1; i++) begin
        cbuf_d[i] = lbuf_q[i];
      end
      cbuf_d[ROW_N-1] = x;
      if (row_sof_q) begin
        row_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      pix_cnt_q   <= '0;
      row_cnt_q   <= '0;
      row_sof_q   <= 1'b0;
      prod_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      k_idx_q     <= '0;
      row_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pix_cnt_q   <= pix_cnt_d;
      row_cnt_q   <= row_cnt_d;
      row_sof_q   <= row_sof_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      k_idx_q     <= k_idx_d;
      row_idx_q   <= row_idx_d;
    end
  end

  // Pixel buffers carry no reset: their contents only matter after a full row is loaded
  always_ff @(posedge clk) begin
    lbuf_q <= lbuf_d;
    cbuf_q <= cbuf_d;
  end

  assign bus.pix_ready = ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.k_idx     = k_idx_q;
  assign bus.row_idx   = row_idx_q;
  assign bus.n0        = prod_q[0];
  assign bus.n1        = prod_q[1];
  assign bus.n2        = prod_q[2];
  assign bus.n3        = prod_q[3];
  assign bus.n4        = prod_q[4];
  assign bus.n5        = prod_q[5];
  assign bus.n6        = prod_q[6];
  assign bus.n7        = prod_q[7];

endmodule

// File: tb/tb_dct_row_mult.sv
// Directed bench for dct_row_mult: uniform-row vector table plus multi-cycle
// streaming, sof-realign and mid-pass reset sequences.
module tb_dct_row_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_row_mult_if bus ();

  dct_row_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam int C_TB [8][8] = '{
    '{11,  11,  11,  11,  11,  11,  11,  11},
    '{16,  13,   9,   3,  -3,  -9, -13, -16},
    '{15,   6,  -6, -15, -15,  -6,   6,  15},
    '{13,  -3, -16,  -9,   9,  16,   3, -13},
    '{11, -11, -11,  11,  11, -11, -11,  11},
    '{ 9, -16,   3,  13, -13,  -3,  16,  -9},
    '{ 6, -15,  15,  -6,  -6,  15, -15,   6},
    '{ 3,  -9,  13, -16,  16, -13,   9,  -3}
  };

  typedef struct {
    logic [7:0] pix;
    int         k;
    int         exp_n [8];
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] row_px [8];
  int         cap_n [8][8];
  int         cap_v [8];
  int         cap_k [8];
  int         cap_r [8];

  function automatic int model_n(input logic [7:0] p, input int k, input int i);
    return (int'(p) - 128) * C_TB[k][i];
  endfunction

  function automatic logic [7:0] stream_px(input int r, input int p);
    return 8'((37 * r + 29 * p + 11) % 256);
  endfunction

  function automatic int get_n(input int i);
    case (i)
      0: return int'(bus.n0);
      1: return int'(bus.n1);
      2: return int'(bus.n2);
      3: return int'(bus.n3);
      4: return int'(bus.n4);
      5: return int'(bus.n5);
      6: return int'(bus.n6);
      default: return int'(bus.n7);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_row(input bit with_sof);
    for (int p = 0; p < 8; p++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = row_px[p];
      bus.sof       = with_sof && (p == 0);
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic capture_pass();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      cap_v[c] = int'(bus.out_valid);
      cap_k[c] = int'(bus.k_idx);
      cap_r[c] = int'(bus.row_idx);
      for (int i = 0; i < 8; i++) cap_n[c][i] = get_n(i);
    end
  endtask

  task automatic check_pass(input string tag, input int exp_row);
    chk($sformatf("%s_row", tag), cap_r[0], exp_row);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s_valid[%0d]", tag, c), cap_v[c], 1);
      chk($sformatf("%s_k[%0d]", tag, c), cap_k[c], c);
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s_n%0d_k%0d", tag, i, c), cap_n[c][i], model_n(row_px[i], c, i));
    end
    @(posedge clk); #1;
    chk($sformatf("%s_valid_after", tag), int'(bus.out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{8'd128, 3, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{8'd255, 0, '{1397, 1397, 1397, 1397, 1397, 1397, 1397, 1397}};
    vecs[2] = '{8'd255, 1, '{2032, 1651, 1143, 381, -381, -1143, -1651, -2032}};
    vecs[3] = '{8'd0,   1, '{-2048, -1664, -1152, -384, 384, 1152, 1664, 2048}};
    vecs[4] = '{8'd0,   4, '{-1408, 1408, 1408, -1408, -1408, 1408, 1408, -1408}};
    vecs[5] = '{8'd130, 2, '{30, 12, -12, -30, -30, -12, 12, 30}};
    vecs[6] = '{8'd127, 7, '{-3, 9, -13, 16, -16, 13, -9, 3}};
    vecs[7] = '{8'd138, 3, '{130, -30, -160, -90, 90, 160, 30, -130}};
    vecs[8] = '{8'd120, 5, '{-72, 128, -24, -104, 104, 24, -128, 72}};
    vecs[9] = '{8'd132, 6, '{24, -60, 60, -24, -24, 60, -60, 24}};

    rst = 1'b1;
    bus.sof = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_k_idx", int'(bus.k_idx), 0);
    chk("rst_row_idx", int'(bus.row_idx), 0);
    chk("rst_n0", get_n(0), 0);
    chk("rst_n7", get_n(7), 0);
    chk("rst_pix_ready", int'(bus.pix_ready), 0);
    rst = 1'b0;
    #1;
    chk("pix_ready_after_rst", int'(bus.pix_ready), 1);

    // Uniform-row vectors: one row per entry, compare the entry's k set
    for (int v = 0; v < 10; v++) begin
      for (int p = 0; p < 8; p++) row_px[p] = vecs[v].pix;
      send_row(1'b0);
      capture_pass();
      chk($sformatf("vec%0d_valid", v), cap_v[vecs[v].k], 1);
      chk($sformatf("vec%0d_k", v), cap_k[vecs[v].k], vecs[v].k);
      for (int i = 0; i < 8; i++)
        chk($sformatf("vec%0d_n%0d", v, i), cap_n[vecs[v].k][i], vecs[v].exp_n[i]);
      @(posedge clk); #1;
    end

    // Non-uniform row checked against the coefficient model over the whole pass
    row_px = '{8'd3, 8'd250, 8'd128, 8'd77, 8'd200, 8'd10, 8'd140, 8'd255};
    send_row(1'b1);
    capture_pass();
    check_pass("mixed", 0);

    // Three back-to-back rows: contiguous valid, k wraps, row_idx 0,1,2
    begin
      int first_v = -1;
      int last_v = -1;
      int nvalid = 0;
      for (int c = 0; c < 34; c++) begin
        bus.pix_valid = (c < 24);
        bus.sof       = (c == 0);
        bus.pix_in    = (c < 24) ? stream_px(c / 8, c % 8) : 8'd0;
        @(posedge clk); #1;
        chk($sformatf("stream_ready[%0d]", c), int'(bus.pix_ready), 1);
        if (bus.out_valid) begin
          nvalid++;
          if (first_v < 0) first_v = c;
          last_v = c;
        end
        if (c >= 8 && c <= 31) begin
          chk($sformatf("stream_k[%0d]", c), int'(bus.k_idx), (c - 8) % 8);
          chk($sformatf("stream_row[%0d]", c), int'(bus.row_idx), (c - 8) / 8);
          for (int i = 0; i < 8; i++)
            chk($sformatf("stream_n%0d[%0d]", i, c), get_n(i),
                model_n(stream_px((c - 8) / 8, i), (c - 8) % 8, i));
        end
      end
      bus.pix_valid = 1'b0;
      bus.sof = 1'b0;
      chk("stream_valid_count", nvalid, 24);
      chk("stream_first_valid", first_v, 8);
      chk("stream_last_valid", last_v, 31);
    end

    // Five stray pixels then a sof row: only the sof row produces a pass
    begin
      int nvalid = 0;
      int first_v = -1;
      for (int c = 0; c < 24; c++) begin
        bus.pix_valid = (c < 13);
        bus.sof       = (c == 5);
        bus.pix_in    = (c < 5) ? 8'd255 : ((c < 13) ? stream_px(7, c - 5) : 8'd0);
        @(posedge clk); #1;
        if (bus.out_valid) begin
          nvalid++;
          if (first_v < 0) first_v = c;
        end
        if (c >= 13 && c <= 20) begin
          chk($sformatf("sof_k[%0d]", c), int'(bus.k_idx), c - 13);
          chk($sformatf("sof_row[%0d]", c), int'(bus.row_idx), 0);
          for (int i = 0; i < 8; i++)
            chk($sformatf("sof_n%0d[%0d]", i, c), get_n(i), model_n(stream_px(7, i), c - 13, i));
        end
      end
      bus.pix_valid = 1'b0;
      bus.sof = 1'b0;
      chk("sof_valid_count", nvalid, 8);
      chk("sof_first_valid", first_v, 13);
    end

    // Reset while the FSM is at k=3 abandons the pass
    begin
      int nvalid = 0;
      row_px = '{8'd250, 8'd5, 8'd199, 8'd60, 8'd0, 8'd255, 8'd90, 8'd170};
      send_row(1'b0);
      @(posedge clk); #1;
      chk("rstrun_k0", int'(bus.k_idx), 0);
      chk("rstrun_row_before", int'(bus.row_idx), 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rstrun_k2", int'(bus.k_idx), 2);
      rst = 1'b1;
      #1;
      chk("rstrun_pix_ready", int'(bus.pix_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstrun_out_valid", int'(bus.out_valid), 0);
      chk("rstrun_row_idx", int'(bus.row_idx), 0);
      chk("rstrun_k_idx", int'(bus.k_idx), 0);
      for (int i = 0; i < 8; i++) chk($sformatf("rstrun_n%0d", i), get_n(i), 0);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (bus.out_valid) nvalid++;
      end
      chk("rstrun_no_residual", nvalid, 0);
      send_row(1'b0);
      capture_pass();
      check_pass("post_rst", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dct_row_mult.md
# dct_row_mult

First stage of the 1-D row DCT, directly upstream of the 8-input pipelined adder tree.
- Collects 8 serial 8-bit pixels into a row and level-shifts them to signed.
- Then, for each output coefficient index k = 0..7 in turn, presents eight registered 14-bit signed products x_i·C[k][i] on n0..n7, one k per cycle.
- The adder tree sums each product set and produces the 12-bit DCT coefficient.

## Interface
Parameters:
- `PIX_W`, 8, pixel width (unsigned input)
- `COEF_W`, 6, signed coefficient width
- `PROD_W`, 14, product width on n0..n7

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `sof` in 1: start of frame; realigns pixel counter
- `pix_valid` in 1: pixel strobe
- `pix_in` in 8: unsigned pixel
- `pix_ready` in→out 1: out; 1 whenever `rst`=0
- `n0`..`n7` out 14 each: signed products x_i·C[k][i]
- `out_valid` out 1: n0..n7 and k_idx valid this cycle
- `k_idx` out 3: coefficient index of current product set
- `row_idx` out 3: row number within 8×8 block, for downstream transpose

## Operation
- **Level shift.** x = pix_in − 128, computed as pix_in with MSB inverted; result is signed 8-bit [−128, 127].
- **Load side.**
  - `pix_cnt` (0..7) increments on each accepted pixel (`pix_valid`=1).
  - The accepted pixel is written to `lbuf[pix_cnt]`.
  - `sof`=1 forces `pix_cnt` to 0 before the write, so a `sof` pixel is always x_0. Any partial row is discarded.
- **Transfer.**
  - On the accept of pixel 7, `cbuf` ← {lbuf[0..6], incoming x}, the compute FSM enters RUN with k=0, and `pix_cnt` wraps to 0.
  - This is legal from IDLE or from RUN at k=7. At one pixel per cycle the two always coincide, so no stall exists.
- **Compute FSM.**
  - IDLE → RUN on transfer.
  - RUN: k increments each cycle.
  - At k=7: go to RUN with k=0 if a transfer occurs that cycle, else go to IDLE.
- **Products.**
  - Each cycle in RUN, register n_i ← sign-extend(x_i · C[k][i]) into 14 bits.
  - Register `k_idx` ← k and set `out_valid` ← 1.
  - In IDLE, `out_valid` ← 0 and n_i hold their last value.
- **Row counter.** `row_idx` increments modulo 8 on each completed RUN pass. It resets to 0 on `sof`-aligned transfer and on `rst`.
- **Coefficients.** C[k][i] = round(32·c_k·cos((2i+1)kπ/16)), with c_0 = 1/(2√2) and c_k = 1/2 otherwise.
  - k=0: all 11.
  - k=1: 16, 13, 9, 3, −3, −9, −13, −16.
  - k=2: 15, 6, −6, −15, −15, −6, 6, 15.
  - k=4: 11, −11, −11, 11, 11, −11, −11, 11.
- **Width guarantee.** Maximum |product| = 128·16 = 2048, so 14 bits never overflow. The downstream sum /8 fits 12 bits.
- **Reset.** `rst`=1 synchronously sets:
  - `pix_cnt`=0, FSM=IDLE, k=0
  - `out_valid`=0, `k_idx`=0, `row_idx`=0, n0..n7=0
  - lbuf/cbuf need no reset
  - `pix_ready`=0 during reset
  - Reset mid-row or mid-RUN abandons all work; no output is produced for that row.
- **Simultaneous events.** `sof` together with `pix_valid` on the 8th position restarts at x_0; no transfer occurs.

## Timing
- Pixel 7 is sampled at edge E.
- `out_valid`=1 with `k_idx`=0 after edge E+1, and `k_idx`=7 after edge E+8.
- Latency from last pixel to first product: 1 cycle registered.
- Continuous pixel stream: 8 product sets per 8 cycles with no bubble; `out_valid` stays high across row boundaries.
- Downstream adder latency is 5 cycles. The consumer delays `out_valid`, `k_idx` and `row_idx` by 5 to align with `dct`.

## Structure
- Package `dct_pkg`:
  - `PIX_W`, `COEF_W`, `PROD_W`
  - 8×8 signed coefficient table constant
  - FSM state enum {IDLE, RUN}
- Sub-module `dct_coef_rom`: input k, output eight 6-bit signed coefficients, combinational from the package table.
- Eight signed multipliers are inferred in the top level.

## Test plan
- Row of eight 128 (x=0) → 8 cycles `out_valid`=1, k_idx 0..7, all n_i=0.
- Row of eight 255 (x=127):
  - k=0: all n_i=1397 (14'h0575).
  - k=1: n0=2032 (14'h07F0), n7=−2032 (14'h3810).
- Row of eight 0 (x=−128), k=1: n0=−2048 (14'h3800), n7=2048 (14'h0800), n3=−384 (14'h3E80).
- Three rows streamed with `pix_valid` held 1:
  - 24 contiguous `out_valid` cycles.
  - `row_idx` 0, 1, 2.
  - `pix_ready` constant 1.
- 5 pixels, then `sof` with a new 8-pixel row → only one product pass, using the new row; the first 5 pixels produce no output.
- `rst` asserted at RUN k=3 for one cycle → next cycle `out_valid`=0, n_i=0, `row_idx`=0. A following full row produces a normal 8-cycle pass.
